// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed HH:MM:SS seven-segment scanner.
package clock_disp_pkg;

  // Segment patterns, {g,f,e,d,c,b,a}, active-high form.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Digit slot indices; slot 0 is the rightmost digit.
  localparam logic [2:0] DIG_SEC_L = 3'd0;
  localparam logic [2:0] DIG_SEC_M = 3'd1;
  localparam logic [2:0] DIG_MIN_L = 3'd2;
  localparam logic [2:0] DIG_MIN_M = 3'd3;
  localparam logic [2:0] DIG_HR_L  = 3'd4;
  localparam logic [2:0] DIG_HR_M  = 3'd5;

  // Decimal point acts as the separator after the minute and hour units.
  localparam logic [5:0] DP_MASK = 6'b010100;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern (active-high); non-BCD codes show a dash.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; anything above 9 is flagged visibly as '-'.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed display scanner with per-frame snapshot, anti-ghost gap and alarm flash.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hour_msb,
  input  logic [3:0] hour_lsb,
  input  logic [3:0] min_msb,
  input  logic [3:0] min_lsb,
  input  logic [3:0] sec_msb,
  input  logic [3:0] sec_lsb,
  input  logic       alarm,
  input  logic       en,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en,
  output logic       frame_start
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [5:0] DIG_OFF = {6{ACTIVE_LOW}};

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [2:0]       dig_ptr;
  logic             frame_wrap;

  logic [1:0]       snap_hr_m;
  logic [3:0]       snap_hr_l, snap_min_m, snap_min_l, snap_sec_m, snap_sec_l;

  logic             alarm_d;
  logic             alarm_rise;
  phase_e           phase, phase_nxt;
  logic [BLK_W-1:0] blink_cnt, blink_cnt_nxt;

  logic             vld_p0;
  logic [2:0]       sel_p0;

  logic [3:0]       bcd_sel;
  logic [6:0]       seg_raw;
  logic [5:0]       dig_onehot;
  logic             show;

  logic [6:0]       seg_p1;
  logic             dp_p1;
  logic [5:0]       dig_en_p1;
  logic             frame_start_p1;

  assign tick       = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (dig_ptr == DIG_SEC_L);
  assign alarm_rise = alarm && !alarm_d;

  // Slot-rate prescaler and pointer to the digit the next tick will select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      dig_ptr <= DIG_SEC_L;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        dig_ptr <= (dig_ptr == DIG_HR_M) ? DIG_SEC_L : dig_ptr + 3'd1;
    end
  end

  // Whole-frame snapshot so the six digits of one frame never tear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_hr_m  <= '0;
      snap_hr_l  <= '0;
      snap_min_m <= '0;
      snap_min_l <= '0;
      snap_sec_m <= '0;
      snap_sec_l <= '0;
    end else if (frame_wrap) begin
      snap_hr_m  <= hour_msb;
      snap_hr_l  <= hour_lsb;
      snap_min_m <= min_msb;
      snap_min_l <= min_lsb;
      snap_sec_m <= sec_msb;
      snap_sec_l <= sec_lsb;
    end
  end

  // Blink phase state register and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= PHASE_ON;
      blink_cnt <= '0;
      alarm_d   <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      blink_cnt <= blink_cnt_nxt;
      alarm_d   <= alarm;
    end
  end

  // Blink next state: alarm edge restarts the flash visible, even on a frame wrap.
  always_comb begin
    phase_nxt     = phase;
    blink_cnt_nxt = blink_cnt;
    if (alarm_rise) begin
      phase_nxt     = PHASE_ON;
      blink_cnt_nxt = '0;
    end else if (frame_wrap) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_nxt = '0;
        phase_nxt     = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end
    end
  end

  // Stage p0: latch the slot chosen by this tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      sel_p0 <= DIG_SEC_L;
    end else begin
      vld_p0 <= tick;
      if (tick)
        sel_p0 <= dig_ptr;
    end
  end

  // Pick the snapshot digit for the latched slot and decide whether it may light.
  always_comb begin
    bcd_sel = '0;
    case (sel_p0)
      DIG_SEC_L: bcd_sel = snap_sec_l;
      DIG_SEC_M: bcd_sel = snap_sec_m;
      DIG_MIN_L: bcd_sel = snap_min_l;
      DIG_MIN_M: bcd_sel = snap_min_m;
      DIG_HR_L:  bcd_sel = snap_hr_l;
      DIG_HR_M:  bcd_sel = {2'b00, snap_hr_m};
      default:   bcd_sel = '0;
    endcase
    dig_onehot = 6'b000001 << sel_p0;
    show = en
        && (!alarm || (phase == PHASE_ON) || alarm_rise)
        && !(blank_lz && (sel_p0 == DIG_HR_M) && (snap_hr_m == 2'd0));
  end

  seg7_decode u_dec (
    .bcd (bcd_sel),
    .seg (seg_raw)
  );

  // Stage p1: blank digits the cycle after a tick, then drive the new slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_p1         <= SEG_OFF;
      dp_p1          <= ACTIVE_LOW;
      dig_en_p1      <= DIG_OFF;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= 1'b0;
      if (tick) begin
        dig_en_p1 <= DIG_OFF;
      end else if (vld_p0) begin
        seg_p1         <= seg_raw ^ SEG_OFF;
        dp_p1          <= DP_MASK[sel_p0] ^ ACTIVE_LOW;
        dig_en_p1      <= (show ? dig_onehot : 6'b000000) ^ DIG_OFF;
        frame_start_p1 <= (sel_p0 == DIG_SEC_L);
      end
    end
  end

  assign seg         = seg_p1;
  assign dp          = dp_p1;
  assign dig_en      = dig_en_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: stimulus queues per-slot expectations, monitor checks each slot.
module tb_clock_display_scan;

  localparam int P  = 4;
  localparam int FR = 6 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] hour_msb = '0;
  logic [3:0] hour_lsb = '0, min_msb = '0, min_lsb = '0, sec_msb = '0, sec_lsb = '0;
  logic       alarm = 1'b0, en = 1'b0, blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_en;
  logic       frame_start;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(P), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset),
    .hour_msb(hour_msb), .hour_lsb(hour_lsb), .min_msb(min_msb), .min_lsb(min_lsb),
    .sec_msb(sec_msb), .sec_lsb(sec_lsb),
    .alarm(alarm), .en(en), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .dig_en(dig_en), .frame_start(frame_start)
  );

  // Rising edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: gap cycle after each tick must be dark; each slot load pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (cyc >= P && (cyc % P) == 0) begin
        n_run++;
        if (dig_en !== 6'b0 || frame_start !== 1'b0) begin
          n_fail++;
          $display("FAIL gap cyc=%0d got dig_en=%b fs=%b need dig_en=000000 fs=0", cyc, dig_en, frame_start);
        end
      end else if (cyc >= P + 1 && ((cyc - 1) % P) == 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++;
        if (seg !== e.seg || dp !== e.dp || dig_en !== e.dig || frame_start !== e.fs) begin
          n_fail++;
          $display("FAIL slot cyc=%0d got seg=%h dp=%b dig_en=%b fs=%b need seg=%h dp=%b dig_en=%b fs=%b",
                   cyc, seg, dp, dig_en, frame_start, e.seg, e.dp, e.dig, e.fs);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_off(input string name);
    n_run++;
    if (seg !== 7'h00 || dp !== 1'b0 || dig_en !== 6'h00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got seg=%h dp=%b dig_en=%b fs=%b need all zero", name, seg, dp, dig_en, frame_start);
    end
  endtask

  // Apply inputs just before frame m's capture tick and queue its six expected slots.
  task automatic do_frame(input int m, input logic [1:0] hm, input logic [3:0] hl, mm, ml, sm, sl,
                          input logic en_v, al_v, blz_v, vis, b5,
                          input logic [6:0] s0, s1, s2, s3, s4, s5);
    logic [6:0] s [6];
    exp_t e;
    wait_cyc(P - 1 + FR * m);
    hour_msb = hm; hour_lsb = hl; min_msb = mm; min_lsb = ml; sec_msb = sm; sec_lsb = sl;
    en = en_v; alarm = al_v; blank_lz = blz_v;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4; s[5] = s5;
    for (int k = 0; k < 6; k++) begin
      e.seg = s[k];
      e.dp  = (k == 2 || k == 4);
      e.dig = (vis && !(k == 5 && b5)) ? (6'b000001 << k) : 6'b000000;
      e.fs  = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_off("reset_state");
    reset = 1'b1;

    //          m  hm    hl    mm    ml    sm    sl    en al blz vis b5  s0     s1     s2     s3     s4     s5
    do_frame(0,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 0, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(1,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 0, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    wait_cyc(P + 1 + FR * 1 + 3 * P);
    sec_lsb = 4'd7; hour_lsb = 4'd9;
    do_frame(2,  2'd1, 4'd9, 4'd3, 4'd4, 4'd5, 4'd7, 1, 0, 0, 1, 0, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h6F, 7'h06);
    do_frame(3,  2'd0, 4'd9, 4'd3, 4'd4, 4'd5, 4'd7, 1, 0, 1, 1, 1, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h6F, 7'h3F);
    do_frame(4,  2'd0, 4'd9, 4'd3, 4'd4, 4'd5, 4'd7, 1, 0, 0, 1, 0, 7'h07, 7'h6D, 7'h66, 7'h4F, 7'h6F, 7'h3F);
    do_frame(5,  2'd0, 4'd8, 4'd3, 4'hC, 4'd5, 4'd7, 1, 0, 0, 1, 0, 7'h07, 7'h6D, 7'h40, 7'h4F, 7'h7F, 7'h3F);
    do_frame(6,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 0, 0, 0, 0, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(7,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(8,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(9,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 0, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(10, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 0, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(11, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(12, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(13, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 1, 0, 0, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(14, 2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 0, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);

    // Asynchronous reset in the middle of frame 14, while slot 2 is lit.
    wait_cyc(P + 1 + FR * 14 + 2 * P);
    #2 reset = 1'b0;
    #1 check_off("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_off("held_reset");
    reset = 1'b1;

    do_frame(0,  2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1, 0, 0, 1, 0, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
    do_frame(1,  2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1, 1, 0, 0, 1, 0, 7'h06, 7'h3F, 7'h6F, 7'h6D, 7'h4F, 7'h5B);

    for (int i = 0; i < 4 * FR && exp_q.size() > 0; i++) @(negedge clk);
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending slots need 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
